// File: rtl/game_pkg.sv
// Shared game constants, state encodings and the jump controller FSM type.
package game_pkg;

    localparam logic [2:0] ST_WAIT = 3'd0;
    localparam logic [2:0] ST_INFO = 3'd1;
    localparam logic [2:0] ST_GAME = 3'd2;
    localparam logic [2:0] ST_WIN  = 3'd3;
    localparam logic [2:0] ST_LOSE = 3'd4;

    localparam int SCR_LEFT   = 200;
    localparam int SCR_RIGHT  = 440;
    localparam int SCR_BOTTOM = 480;

    localparam int BLK_WIDTH  = 32;
    localparam int BLK_HEIGHT = 16;

    localparam logic [2:0] BUMP_NONE  = 3'd0;
    localparam logic [2:0] BUMP_FIXED = 3'd1;

    typedef enum logic [2:0] {
        PJ_IDLE,
        PJ_AIR,
        PJ_SCAN,
        PJ_COMMIT,
        PJ_DEAD
    } pj_state_t;

endpackage

// File: rtl/block_overlap_chk.sv
// Landing test for one block: feet sweep over the block top and the x spans overlap.
module block_overlap_chk #(
    parameter int PLAYER_W = 16,
    parameter int BLK_W    = 32
) (
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    input  logic [9:0] cand_y,
    input  logic [9:0] blk_x,
    input  logic [9:0] blk_y,
    output logic       hit
);

    logic [10:0] p_right;
    logic [10:0] b_right;

    assign p_right = {1'b0, player_x} + 11'(PLAYER_W);
    assign b_right = {1'b0, blk_x} + 11'(BLK_W);

    assign hit = (player_y <= blk_y) && (blk_y <= cand_y) &&
                 (p_right > {1'b0, blk_x}) && ({1'b0, player_x} < b_right);

endmodule

// File: rtl/player_jump_ctrl.sv
// Player vertical physics, steering and serial block-landing scan.
// Optional mid-air jump is enabled by defining AIR_JUMP_EN.
module player_jump_ctrl
    import game_pkg::*;
#(
    parameter int NUM_BLK  = 15,
    parameter int JUMP_V   = 12,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 12,
    parameter int BASE_Y   = 400,
    parameter int HOLD_Y   = 120,
    parameter int PLAYER_W = 16,
    parameter int BLK_W    = 32,
    parameter int X_STEP   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_en,
    input  logic [2:0] state,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    output logic [3:0] blk_idx,
    input  logic [9:0] blk_x,
    input  logic [9:0] blk_y,
    output logic [9:0] player_x,
    output logic [9:0] player_y,
    output logic [2:0] bump,
    output logic [9:0] movement,
    output logic       hold,
    output logic       fall_out
);

    localparam logic [9:0] X_RST    = 10'd312;
    localparam logic [9:0] Y_RST    = 10'd460;
    localparam logic [9:0] X_MIN    = 10'(SCR_LEFT);
    localparam logic [9:0] X_MAX    = 10'(SCR_RIGHT - PLAYER_W);
    localparam logic [9:0] XS       = 10'(X_STEP);
    localparam logic [9:0] BOTTOM_V = 10'(SCR_BOTTOM);
    localparam logic [9:0] BASE_V   = 10'(BASE_Y);
    localparam logic [9:0] HOLD_V   = 10'(HOLD_Y);
    localparam logic [3:0] LAST_IDX = 4'(NUM_BLK - 1);
    localparam logic signed [5:0] JV_S   = 6'(JUMP_V);
    localparam logic signed [5:0] GR_S   = 6'(GRAVITY);
    localparam logic signed [5:0] MF_NEG = 6'(-MAX_FALL);

    pj_state_t         cur_st, nxt_st;
    logic signed [5:0] vel, vel_n, vdec;
    logic [9:0]        x_n, y_n, x_step, mov_n, win_y, wy_n, cand_y;
    logic [10:0]       cand_full;
    logic [3:0]        idx_n, win_idx, wi_n;
    logic [2:0]        bump_n;
    logic              hold_n, fo_n, win_hit, wh_n, hit;

    // 11-bit intermediate: bit 10 set means the feet went above the screen top.
    assign cand_full = {1'b0, player_y} - {{5{vel[5]}}, vel};
    assign cand_y    = cand_full[10] ? 10'd0 : cand_full[9:0];
    assign vdec      = vel - GR_S;

    always_comb begin
        x_step = player_x;
        if (btn_left && !btn_right)
            x_step = (player_x < X_MIN + XS) ? X_MIN : player_x - XS;
        else if (btn_right && !btn_left)
            x_step = (player_x + XS > X_MAX) ? X_MAX : player_x + XS;
    end

    block_overlap_chk #(.PLAYER_W(PLAYER_W), .BLK_W(BLK_W)) u_chk (
        .player_x (player_x),
        .player_y (player_y),
        .cand_y   (cand_y),
        .blk_x    (blk_x),
        .blk_y    (blk_y),
        .hit      (hit)
    );

`ifdef AIR_JUMP_EN
    logic air_ok, air_ok_n, jmp_last, jmp_last_n;
`else
    logic jump_unused;
    assign jump_unused = btn_jump;
`endif

    always_comb begin
        nxt_st = cur_st;
        x_n    = player_x;
        y_n    = player_y;
        vel_n  = vel;
        idx_n  = blk_idx;
        bump_n = bump;
        mov_n  = movement;
        hold_n = hold;
        fo_n   = 1'b0;
        wh_n   = win_hit;
        wy_n   = win_y;
        wi_n   = win_idx;
`ifdef AIR_JUMP_EN
        air_ok_n   = air_ok;
        jmp_last_n = jmp_last;
`endif
        if (state != ST_GAME) begin
            nxt_st = PJ_IDLE;
            x_n    = X_RST;
            y_n    = Y_RST;
            vel_n  = JV_S;
            idx_n  = 4'd0;
            bump_n = BUMP_NONE;
            mov_n  = 10'd0;
            hold_n = 1'b0;
            wh_n   = 1'b0;
            wy_n   = 10'd0;
            wi_n   = 4'd0;
`ifdef AIR_JUMP_EN
            air_ok_n   = 1'b1;
            jmp_last_n = btn_jump;
`endif
        end else begin
            unique case (cur_st)
                PJ_IDLE: nxt_st = PJ_AIR;
                PJ_AIR: if (tick_en) begin
                    x_n = x_step;
`ifdef AIR_JUMP_EN
                    jmp_last_n = btn_jump;
`endif
                    if (vel > 6'sd0) begin
                        y_n    = cand_y;
                        vel_n  = vdec;
                        hold_n = (cand_y < HOLD_V);
                    end
`ifdef AIR_JUMP_EN
                    else if (btn_jump && !jmp_last && air_ok) begin
                        vel_n    = JV_S;
                        air_ok_n = 1'b0;
                    end
`endif
                    else begin
                        nxt_st = PJ_SCAN;
                        idx_n  = 4'd0;
                        wh_n   = 1'b0;
                    end
                end
                PJ_SCAN: begin
                    // Strict compare keeps the lowest index on equal heights.
                    if (hit && (!win_hit || blk_y < win_y)) begin
                        wh_n = 1'b1;
                        wy_n = blk_y;
                        wi_n = blk_idx;
                    end
                    if (blk_idx == LAST_IDX) nxt_st = PJ_COMMIT;
                    else                     idx_n  = blk_idx + 4'd1;
                end
                PJ_COMMIT: begin
                    idx_n  = 4'd0;
                    nxt_st = PJ_AIR;
                    if (win_hit) begin
                        y_n    = win_y;
                        vel_n  = JV_S;
                        bump_n = BUMP_FIXED;
                        mov_n  = (win_y < BASE_V) ? BASE_V - win_y : 10'd0;
                        hold_n = (win_y < HOLD_V);
`ifdef AIR_JUMP_EN
                        air_ok_n = 1'b1;
`endif
                    end else begin
                        y_n    = cand_y;
                        vel_n  = (vdec < MF_NEG) ? MF_NEG : vdec;
                        bump_n = BUMP_NONE;
                        mov_n  = 10'd0;
                        hold_n = (cand_y < HOLD_V);
                        if (cand_y > BOTTOM_V) begin
                            fo_n   = 1'b1;
                            nxt_st = PJ_DEAD;
                        end
                    end
                end
                PJ_DEAD: ;
                default: nxt_st = PJ_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_st   <= PJ_IDLE;
            player_x <= X_RST;
            player_y <= Y_RST;
            vel      <= JV_S;
            blk_idx  <= 4'd0;
            bump     <= BUMP_NONE;
            movement <= 10'd0;
            hold     <= 1'b0;
            fall_out <= 1'b0;
            win_hit  <= 1'b0;
            win_y    <= 10'd0;
            win_idx  <= 4'd0;
`ifdef AIR_JUMP_EN
            air_ok   <= 1'b1;
            jmp_last <= 1'b0;
`endif
        end else begin
            cur_st   <= nxt_st;
            player_x <= x_n;
            player_y <= y_n;
            vel      <= vel_n;
            blk_idx  <= idx_n;
            bump     <= bump_n;
            movement <= mov_n;
            hold     <= hold_n;
            fall_out <= fo_n;
            win_hit  <= wh_n;
            win_y    <= wy_n;
            win_idx  <= wi_n;
`ifdef AIR_JUMP_EN
            air_ok   <= air_ok_n;
            jmp_last <= jmp_last_n;
`endif
        end
    end

endmodule

// File: tb/tb_player_jump_ctrl.sv
// Directed bench for player_jump_ctrl: rise, landing order, x miss, steering, climb, fall-out, reset.
module tb_player_jump_ctrl;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       rst, tick_en, btn_left, btn_right, btn_jump;
    logic [2:0] state;
    logic [3:0] blk_idx;
    logic [9:0] blk_x, blk_y, player_x, player_y, movement;
    logic [2:0] bump;
    logic       hold, fall_out;

    logic [9:0] bx [16];
    logic [9:0] by [16];
    int checks = 0;
    int failures = 0;
    int fo_cnt = 0;

    assign blk_x = bx[blk_idx];
    assign blk_y = by[blk_idx];

    always #5 clk = ~clk;
    always @(negedge clk) if (fall_out === 1'b1) fo_cnt++;

    player_jump_ctrl dut (
        .clk(clk), .rst(rst), .tick_en(tick_en), .state(state),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
        .blk_idx(blk_idx), .blk_x(blk_x), .blk_y(blk_y),
        .player_x(player_x), .player_y(player_y), .bump(bump),
        .movement(movement), .hold(hold), .fall_out(fall_out)
    );

    task automatic clear_blocks();
        for (int i = 0; i < 16; i++) begin
            bx[i] = 10'd0;
            by[i] = 10'd1000;
        end
    endtask

    task automatic restart();
        @(posedge clk); #1 state = 3'd0;
        repeat (2) @(posedge clk);
        #1 state = 3'd2;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // One tick strobe then enough cycles for a full scan and commit.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 tick_en = 1'b1;
            @(posedge clk); #1 tick_en = 1'b0;
            repeat (18) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; state = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (player_x !== 10'd312) begin failures++; $display("FAIL reset_x got=%0d exp=312", player_x); end
        checks++; if (player_y !== 10'd460) begin failures++; $display("FAIL reset_y got=%0d exp=460", player_y); end
        checks++; if (bump !== 3'd0 || movement !== 10'd0) begin failures++; $display("FAIL reset_bump_mov got=%0d/%0d exp=0/0", bump, movement); end
        checks++; if (hold !== 1'b0 || fall_out !== 1'b0 || blk_idx !== 4'd0) begin failures++; $display("FAIL reset_flags got=%b%b idx=%0d exp=00 idx=0", hold, fall_out, blk_idx); end
        rst = 1'b1;
    endtask

    task automatic test_rise();
        clear_blocks(); restart();
        tick(1);
        checks++; if (player_y !== 10'd448) begin failures++; $display("FAIL rise_t1 got=%0d exp=448", player_y); end
        tick(1);
        checks++; if (player_y !== 10'd437) begin failures++; $display("FAIL rise_t2 got=%0d exp=437", player_y); end
        tick(10);
        checks++; if (player_y !== 10'd382) begin failures++; $display("FAIL rise_peak got=%0d exp=382", player_y); end
        tick(1);
        checks++; if (player_y !== 10'd382 || bump !== 3'd0) begin failures++; $display("FAIL rise_t13 got=%0d bump=%0d exp=382 bump=0", player_y, bump); end
        tick(1);
        checks++; if (player_y !== 10'd383) begin failures++; $display("FAIL fall_t14 got=%0d exp=383", player_y); end
    endtask

    task automatic test_landing_order();
        clear_blocks();
        bx[3] = 10'd300; by[3] = 10'd397;
        bx[9] = 10'd300; by[9] = 10'd395;
        restart(); tick(18);
        checks++; if (player_y !== 10'd395) begin failures++; $display("FAIL land_y got=%0d exp=395", player_y); end
        checks++; if (bump !== 3'd1 || movement !== 10'd5) begin failures++; $display("FAIL land_bump_mov got=%0d/%0d exp=1/5", bump, movement); end
        checks++; if (dut.win_idx !== 4'd9) begin failures++; $display("FAIL land_winner got=%0d exp=9", dut.win_idx); end
        tick(1);
        checks++; if (player_y !== 10'd383 || bump !== 3'd1 || movement !== 10'd5) begin failures++; $display("FAIL land_hold_outputs got=%0d/%0d/%0d exp=383/1/5", player_y, bump, movement); end
    endtask

    task automatic test_tie_and_reset_mid_scan();
        int n;
        clear_blocks();
        bx[3] = 10'd300; by[3] = 10'd395;
        bx[9] = 10'd300; by[9] = 10'd395;
        restart(); tick(18);
        checks++; if (dut.win_idx !== 4'd3 || player_y !== 10'd395) begin failures++; $display("FAIL tie_winner got=%0d y=%0d exp=3 y=395", dut.win_idx, player_y); end
        tick(12);
        @(posedge clk); #1 tick_en = 1'b1;
        @(posedge clk); #1 tick_en = 1'b0;
        n = 0;
        while (blk_idx !== 4'd7 && n < 40) begin @(posedge clk); #1; n++; end
        checks++; if (n >= 40) begin failures++; $display("FAIL scan_reach_idx7 got=%0d exp=7", blk_idx); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (blk_idx !== 4'd0 || bump !== 3'd0) begin failures++; $display("FAIL midscan_rst got idx=%0d bump=%0d exp=0/0", blk_idx, bump); end
        checks++; if (player_y !== 10'd460 || movement !== 10'd0) begin failures++; $display("FAIL midscan_rst_y got=%0d mov=%0d exp=460/0", player_y, movement); end
        rst = 1'b1;
    endtask

    task automatic test_miss_x();
        clear_blocks();
        bx[5] = 10'd340; by[5] = 10'd395;
        bx[6] = 10'd280; by[6] = 10'd395;
        bx[7] = 10'd328; by[7] = 10'd395;
        restart(); tick(17);
        // second strobe lands mid-scan and must be ignored
        @(posedge clk); #1 tick_en = 1'b1;
        @(posedge clk); #1 tick_en = 1'b0;
        repeat (5) @(posedge clk);
        #1 tick_en = 1'b1;
        @(posedge clk); #1 tick_en = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (player_y !== 10'd397 || bump !== 3'd0 || movement !== 10'd0) begin failures++; $display("FAIL miss_x got=%0d/%0d/%0d exp=397/0/0", player_y, bump, movement); end
        tick(1);
        checks++; if (player_y !== 10'd403) begin failures++; $display("FAIL miss_vel got=%0d exp=403", player_y); end
    endtask

    task automatic test_steer();
        clear_blocks();
        for (int k = 0; k < 8; k++) begin
            bx[k] = 10'(192 + 32 * k);
            by[k] = 10'd382;
        end
        restart();
        btn_right = 1'b1; tick(1);
        checks++; if (player_x !== 10'd316) begin failures++; $display("FAIL steer_right got=%0d exp=316", player_x); end
        tick(29);
        checks++; if (player_x !== 10'd424) begin failures++; $display("FAIL steer_clamp_hi got=%0d exp=424", player_x); end
        btn_left = 1'b1; tick(2);
        checks++; if (player_x !== 10'd424) begin failures++; $display("FAIL steer_both got=%0d exp=424", player_x); end
        btn_right = 1'b0; tick(1);
        checks++; if (player_x !== 10'd420) begin failures++; $display("FAIL steer_left got=%0d exp=420", player_x); end
        tick(59);
        checks++; if (player_x !== 10'd200) begin failures++; $display("FAIL steer_clamp_lo got=%0d exp=200", player_x); end
        btn_left = 1'b0;
    endtask

    task automatic test_climb();
        clear_blocks();
        bx[0] = 10'd296; by[0] = 10'd382;
        bx[1] = 10'd296; by[1] = 10'd304;
        bx[2] = 10'd296; by[2] = 10'd226;
        bx[3] = 10'd296; by[3] = 10'd148;
        bx[4] = 10'd296; by[4] = 10'd70;
        restart(); tick(13);
        checks++; if (player_y !== 10'd382 || movement !== 10'd18 || bump !== 3'd1) begin failures++; $display("FAIL climb_1 got=%0d mov=%0d exp=382/18", player_y, movement); end
        tick(13);
        checks++; if (player_y !== 10'd304 || movement !== 10'd96) begin failures++; $display("FAIL climb_2 got=%0d mov=%0d exp=304/96", player_y, movement); end
        tick(26);
        checks++; if (player_y !== 10'd148 || movement !== 10'd252 || hold !== 1'b0) begin failures++; $display("FAIL climb_4 got=%0d mov=%0d hold=%b exp=148/252/0", player_y, movement, hold); end
        tick(2);
        checks++; if (player_y !== 10'd125 || hold !== 1'b0) begin failures++; $display("FAIL hold_125 got=%0d hold=%b exp=125/0", player_y, hold); end
        tick(1);
        checks++; if (player_y !== 10'd115 || hold !== 1'b1) begin failures++; $display("FAIL hold_115 got=%0d hold=%b exp=115/1", player_y, hold); end
        tick(10);
        checks++; if (player_y !== 10'd70 || movement !== 10'd330 || hold !== 1'b1) begin failures++; $display("FAIL climb_5 got=%0d mov=%0d hold=%b exp=70/330/1", player_y, movement, hold); end
        tick(12);
        checks++; if (player_y !== 10'd0) begin failures++; $display("FAIL top_saturate got=%0d exp=0", player_y); end
    endtask

    task automatic test_fall_out();
        clear_blocks(); restart();
        tick(26);
        checks++; if (player_y !== 10'd472) begin failures++; $display("FAIL fall_pre got=%0d exp=472", player_y); end
        fo_cnt = 0;
        tick(1);
        checks++; if (fo_cnt !== 1) begin failures++; $display("FAIL fall_pulse got=%0d exp=1", fo_cnt); end
        checks++; if (player_y !== 10'd484 || dut.cur_st !== PJ_DEAD) begin failures++; $display("FAIL fall_dead got=%0d st=%0d exp=484/%0d", player_y, dut.cur_st, PJ_DEAD); end
        btn_right = 1'b1; tick(1); btn_right = 1'b0;
        checks++; if (player_y !== 10'd484 || player_x !== 10'd312 || fo_cnt !== 1) begin failures++; $display("FAIL dead_frozen got=%0d x=%0d pulses=%0d exp=484/312/1", player_y, player_x, fo_cnt); end
        @(posedge clk); #1 state = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (player_y !== 10'd460 || player_x !== 10'd312 || bump !== 3'd0 || fall_out !== 1'b0) begin failures++; $display("FAIL leave_game got=%0d x=%0d exp=460/312", player_y, player_x); end
    endtask

    initial begin
        tick_en = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
        clear_blocks();
        test_reset();
        test_rise();
        test_landing_order();
        test_tie_and_reset_mid_scan();
        test_miss_x();
        test_steer();
        test_climb();
        test_fall_out();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
